// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe register pipeline.
package dff_pipe_pkg;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        int unsigned w;
        w = 1;
        while ((1 << w) < (depth + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : dff_pipe_pkg

// File: rtl/dff_stage.sv
// One pipeline slot: W-bit register with async reset, sync clear and enable.
module dff_stage #(
    parameter int unsigned W = 9
) (
    input  logic         Clk,
    input  logic         Resetn,
    input  logic         En,
    input  logic         Clr,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    // Clear beats enable; otherwise hold.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Q <= '0;
        end else if (Clr) begin
            Q <= '0;
        end else if (En) begin
            Q <= D;
        end
    end

endmodule : dff_stage

// File: rtl/dff_pipe.sv
// Valid-tagged delay line with stall, sync clear, occupancy count and
// rise/fall detection between the two newest accepted samples.
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = count_width(DEPTH)
) (
    input  logic             Clk,
    input  logic             Resetn,
    input  logic             En,
    input  logic             Clr,
    input  logic [WIDTH-1:0] D,
    input  logic             Vin,
    output logic [WIDTH-1:0] Q,
    output logic             Qv,
    output logic [CW-1:0]    Count,
    output logic [WIDTH-1:0] Rise,
    output logic [WIDTH-1:0] Fall
);

    localparam int unsigned SW = WIDTH + 1;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } stage_t;

    stage_t          stage_q [DEPTH];
    stage_t          hist_q;
    stage_t          head_d;
    logic [CW-1:0]   count_nxt_c;

    assign head_d = '{v: Vin, d: D};

    // Chain of stages; bubbles travel with the data.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        stage_t stage_d;
        if (i == 0) begin : g_head
            assign stage_d = head_d;
        end else begin : g_body
            assign stage_d = stage_q[i-1];
        end
        dff_stage #(.W(SW)) u_stage (
            .Clk    (Clk),
            .Resetn (Resetn),
            .En     (En),
            .Clr    (Clr),
            .D      (stage_d),
            .Q      (stage_q[i])
        );
    end

    // Previous occupant of stage 0, kept for edge detection.
    dff_stage #(.W(SW)) u_hist (
        .Clk    (Clk),
        .Resetn (Resetn),
        .En     (En),
        .Clr    (Clr),
        .D      (stage_q[0]),
        .Q      (hist_q)
    );

    // One valid enters with Vin, one leaves from the last stage.
    assign count_nxt_c = Count + CW'(Vin) - CW'(stage_q[DEPTH-1].v);

    // Occupancy counter tracking valid slots in the pipe.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            Count <= '0;
        end else if (Clr) begin
            Count <= '0;
        end else if (En) begin
            Count <= count_nxt_c;
        end
    end

    assign Q  = stage_q[DEPTH-1].d;
    assign Qv = stage_q[DEPTH-1].v;

    // Edges only reported when both compared samples are valid.
    assign Rise = (stage_q[0].v && hist_q.v) ? (stage_q[0].d & ~hist_q.d) : '0;
    assign Fall = (stage_q[0].v && hist_q.v) ? (~stage_q[0].d & hist_q.d) : '0;

    a_count_range : assert property (@(posedge Clk) disable iff (!Resetn)
                                     32'(Count) <= 32'(DEPTH));

endmodule : dff_pipe

// File: tb/tb_dff_pipe.sv
// Self-checking bench: DEPTH=4 and DEPTH=1 pipes driven in lockstep and
// compared against a history-of-accepted-samples model.
module tb_dff_pipe;

    localparam int unsigned WIDTH = 8;

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] d;
    } samp_t;

    logic             Clk;
    logic             Resetn;
    logic             En;
    logic             Clr;
    logic             Vin;
    logic [WIDTH-1:0] D;

    logic [WIDTH-1:0] q4, rise4, fall4;
    logic             qv4;
    logic [2:0]       cnt4;
    logic [WIDTH-1:0] q1, rise1, fall1;
    logic             qv1;
    logic [0:0]       cnt1;

    int checks;
    int failures;

    // Every sample accepted since the last clear/reset, oldest first.
    samp_t acc[$];

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(4)) dut4 (
        .Clk(Clk), .Resetn(Resetn), .En(En), .Clr(Clr), .D(D), .Vin(Vin),
        .Q(q4), .Qv(qv4), .Count(cnt4), .Rise(rise4), .Fall(fall4)
    );

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(1)) dut1 (
        .Clk(Clk), .Resetn(Resetn), .En(En), .Clr(Clr), .D(D), .Vin(Vin),
        .Q(q1), .Qv(qv1), .Count(cnt1), .Rise(rise1), .Fall(fall1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sample accepted 'back' accepts ago (1 = newest); empty slots read as zero.
    function automatic samp_t pick(input int unsigned back);
        samp_t s;
        s = '0;
        if (acc.size() >= back) s = acc[acc.size() - back];
        return s;
    endfunction

    function automatic int unsigned exp_count(input int unsigned n);
        int unsigned c;
        c = 0;
        for (int unsigned k = 1; k <= n; k++) begin
            if (pick(k).v) c++;
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] exp_rise();
        samp_t a, b;
        a = pick(1);
        b = pick(2);
        return (a.v && b.v) ? (a.d & ~b.d) : '0;
    endfunction

    function automatic logic [WIDTH-1:0] exp_fall();
        samp_t a, b;
        a = pick(1);
        b = pick(2);
        return (a.v && b.v) ? (~a.d & b.d) : '0;
    endfunction

    task automatic check_all();
        samp_t e4, e1;
        e4 = pick(4);
        e1 = pick(1);
        chk("q4",    32'(q4),    32'(e4.d));
        chk("qv4",   32'(qv4),   32'(e4.v));
        chk("cnt4",  32'(cnt4),  exp_count(4));
        chk("rise4", 32'(rise4), 32'(exp_rise()));
        chk("fall4", 32'(fall4), 32'(exp_fall()));
        chk("q1",    32'(q1),    32'(e1.d));
        chk("qv1",   32'(qv1),   32'(e1.v));
        chk("cnt1",  32'(cnt1),  exp_count(1));
        chk("rise1", 32'(rise1), 32'(exp_rise()));
        chk("fall1", 32'(fall1), 32'(exp_fall()));
    endtask

    // Drive one cycle from a negedge, update model at posedge, check at negedge.
    task automatic step(input logic en, input logic clr, input logic vin, input logic [WIDTH-1:0] d);
        samp_t s;
        En  = en;
        Clr = clr;
        Vin = vin;
        D   = d;
        @(posedge Clk);
        if (clr) begin
            acc.delete();
        end else if (en) begin
            s = '{v: vin, d: d};
            acc.push_back(s);
            if (acc.size() > 8) void'(acc.pop_front());
        end
        @(negedge Clk);
        check_all();
    endtask

    // Assert reset mid-cycle and check outputs clear before any edge.
    task automatic do_reset();
        #2;
        Resetn = 1'b0;
        acc.delete();
        #1;
        check_all();
        @(negedge Clk);
        Resetn = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        Resetn   = 1'b0;
        En       = 1'b0;
        Clr      = 1'b0;
        Vin      = 1'b0;
        D        = '0;
        #1;
        check_all();
        @(negedge Clk);
        Resetn = 1'b1;

        // Fill and latency.
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 1'b0, 1'b1, 8'(k * 17));
            if (k == 4) begin
                chk("fill_q_const",  32'(q4),  32'h11);
                chk("fill_qv_const", 32'(qv4), 32'h1);
            end
        end
        chk("fill_cnt_const", 32'(cnt4), 32'd4);

        // Reset with a loaded pipe.
        do_reset();

        // Stall and bubbles; D wiggles while stalled and must not be captured.
        step(1'b1, 1'b0, 1'b1, 8'hA0);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'hA1);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b1, 8'($urandom));
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            if (k == 0) chk("stall_a0_q", 32'(q4), 32'hA0);
            if (k == 2) chk("stall_a1_q", 32'(q4), 32'hA1);
        end

        // Clear wins over enable.
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 1'b1, 8'($urandom));
        chk("clr_pre_cnt", 32'(cnt4), 32'd4);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("clr_cnt_const", 32'(cnt4), 32'd0);
        chk("clr_q1_const",  32'(q1),   32'd0);

        // Edge detection.
        step(1'b1, 1'b0, 1'b1, 8'b0000_1111);
        step(1'b1, 1'b0, 1'b1, 8'b0101_0101);
        chk("edge_rise_const", 32'(rise4), 32'h50);
        chk("edge_fall_const", 32'(fall4), 32'h0A);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("edge_rise_inv", 32'(rise4), 32'h0);

        // Single-stage build behaviour.
        step(1'b1, 1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b1, 8'h3C);
        chk("d1_q_first", 32'(q1), 32'h3C);
        step(1'b1, 1'b0, 1'b1, 8'hC3);
        chk("d1_q_second", 32'(q1),    32'hC3);
        chk("d1_cnt",      32'(cnt1),  32'd1);
        chk("d1_rise",     32'(rise1), 32'hC3);
        chk("d1_fall",     32'(fall1), 32'h3C);

        // Random traffic with occasional clears and resets.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0,
                     $urandom_range(0, 19) == 0,
                     1'($urandom),
                     8'($urandom));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dff_pipe
